// File: rtl/fc_mac_pkg.sv
// Shared helpers for the fully-connected MAC lane array: width derivation,
// sign extension and MSB-first lane slicing.
package fc_mac_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Width that holds the exact sum of 'lanes' products without overflow.
    function automatic int sumWidth(input int dataWidth, input int weightWidth, input int lanes);
        return dataWidth + weightWidth + clog2(lanes);
    endfunction

    function automatic logic [63:0] sext64(input logic [63:0] value, input int width);
        logic [63:0] shifted;
        shifted = value << (64 - width);
        return 64'($signed(shifted) >>> (64 - width));
    endfunction

    // Lane 0 occupies the most significant slice of a packed lane vector.
    function automatic int laneLsb(input int lane, input int lanes, input int width);
        return (lanes - 1 - lane) * width;
    endfunction

endpackage

// File: rtl/fc_mac_adder_tree.sv
// Combinational signed reduction of LANES packed products into one exact sum;
// the parent registers the result.
module fc_mac_adder_tree #(
    parameter int LANES      = 20,
    parameter int PROD_WIDTH = 12,
    parameter int SUM_WIDTH  = 17
) (
    input  logic [LANES*PROD_WIDTH-1:0] prod_i,
    output logic [SUM_WIDTH-1:0]        sum_o
);

    logic signed [PROD_WIDTH-1:0] prodLane;
    logic signed [SUM_WIDTH-1:0]  sumAcc;

    // Written as a chain; synthesis is free to rebalance it into a tree.
    always_comb begin
        sumAcc   = '0;
        prodLane = '0;
        for (int i = 0; i < LANES; i++) begin
            prodLane = prod_i[i*PROD_WIDTH +: PROD_WIDTH];
            sumAcc   = sumAcc + SUM_WIDTH'(prodLane);
        end
    end

    assign sum_o = sumAcc;

endmodule

// File: rtl/fc_mac_array.sv
// Pipelined LANES-wide signed MAC with packet accumulation, bias and overflow flag.
// Optional macro FC_MAC_RELU_EN clamps negative results to zero.
module fc_mac_array
    import fc_mac_pkg::*;
#(
    parameter int LANES        = 20,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]    in_data,
    input  logic [LANES*WEIGHT_WIDTH-1:0]  in_weight,
    input  logic [ACC_WIDTH-1:0]           in_bias,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_data,
    output logic                           out_overflow
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int SUM_WIDTH  = sumWidth(DATA_WIDTH, WEIGHT_WIDTH, LANES);

    logic                         en;
    logic                         accLoad;
    logic signed [DATA_WIDTH-1:0]   laneData;
    logic signed [WEIGHT_WIDTH-1:0] laneWeight;
    logic [LANES*PROD_WIDTH-1:0]  prod_d, prod_q;
    logic                         v1_q, last1_q;
    logic [ACC_WIDTH-1:0]         bias1_q;
    logic [SUM_WIDTH-1:0]         sum_d, sum_q;
    logic                         v2_q, last2_q;
    logic [ACC_WIDTH-1:0]         bias2_q;
    logic [ACC_WIDTH-1:0]         acc_d, acc_q;
    logic                         ovf_d, ovf_q;
    logic                         first_q;
    logic [63:0]                  baseWide, sumWide, totalWide;
    logic [ACC_WIDTH-1:0]         outData_d, outData_q;
    logic                         outValid_q, outOvf_q;

    assign en       = !outValid_q || out_ready;
    assign accLoad  = en && v2_q;
    assign in_ready = en;

    always_comb begin
        prod_d     = '0;
        laneData   = '0;
        laneWeight = '0;
        for (int i = 0; i < LANES; i++) begin
            laneData   = in_data[laneLsb(i, LANES, DATA_WIDTH) +: DATA_WIDTH];
            laneWeight = in_weight[laneLsb(i, LANES, WEIGHT_WIDTH) +: WEIGHT_WIDTH];
            prod_d[laneLsb(i, LANES, PROD_WIDTH) +: PROD_WIDTH] =
                PROD_WIDTH'(laneData) * PROD_WIDTH'(laneWeight);
        end
    end

    fc_mac_adder_tree #(
        .LANES      (LANES),
        .PROD_WIDTH (PROD_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_adder_tree (
        .prod_i (prod_q),
        .sum_o  (sum_d)
    );

    // The add is done exactly in 64 bits; overflow means the wrapped value differs.
    always_comb begin
        baseWide  = sext64(64'(first_q ? bias2_q : acc_q), ACC_WIDTH);
        sumWide   = sext64(64'(sum_q), SUM_WIDTH);
        totalWide = baseWide + sumWide;
        acc_d     = totalWide[ACC_WIDTH-1:0];
        ovf_d     = (totalWide != sext64(64'(acc_d), ACC_WIDTH)) || (!first_q && ovf_q);
`ifdef FC_MAC_RELU_EN
        outData_d = acc_d[ACC_WIDTH-1] ? '0 : acc_d;
`else
        outData_d = acc_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            v1_q       <= 1'b0;
            last1_q    <= 1'b0;
            bias1_q    <= '0;
            prod_q     <= '0;
            v2_q       <= 1'b0;
            last2_q    <= 1'b0;
            bias2_q    <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            first_q    <= 1'b1;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outOvf_q   <= 1'b0;
        end else begin
            if (en) begin
                v1_q    <= in_valid;
                last1_q <= in_last;
                bias1_q <= in_bias;
                prod_q  <= prod_d;
                v2_q    <= v1_q;
                last2_q <= last1_q;
                bias2_q <= bias1_q;
                sum_q   <= sum_d;
            end
            if (accLoad) begin
                acc_q   <= acc_d;
                ovf_q   <= ovf_d;
                first_q <= last2_q;
            end
            if (accLoad && last2_q) begin
                outValid_q <= 1'b1;
                outData_q  <= outData_d;
                outOvf_q   <= ovf_d;
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = outValid_q;
    assign out_data     = outData_q;
    assign out_overflow = outOvf_q;

endmodule
